// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and lock FSM state for the data-memory arbiter
package dmem_arb_pkg;

  localparam int LOCK_MAX_DEF = 8;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-way round-robin pick with a force-to-other override
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_other,
  output logic [1:0] gnt
);

  logic other;

  assign other = ~last;

  always_comb begin
    gnt = 2'b00;
    if (force_other && req[other]) begin
      gnt[other] = 1'b1;
    end else if (req == 2'b11) begin
      gnt[other] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master data-memory arbiter with round-robin and bounded atomic lock
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  lock_state_e   state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic          force_q, force_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_owner_q, rsp_owner_d;

  logic [1:0]    req, lock, rr_gnt, gnt;
  logic          sel, any_gnt;
  logic [3:0]    sel_we;
  logic [CW-1:0] cnt_inc;

  assign req  = {m1_req, m0_req};
  assign lock = {m1_lock, m0_lock};

  rr_pick2 u_pick (
    .req         (req),
    .last        (last_gnt_q),
    .force_other (force_q),
    .gnt         (rr_gnt)
  );

  // While locked only the owner may be granted; reset masks every grant.
  always_comb begin
    gnt = rr_gnt;
    if (state_q == LOCKED) begin
      gnt          = 2'b00;
      gnt[owner_q] = req[owner_q];
    end
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end

  assign sel       = gnt[1];
  assign any_gnt   = |gnt;
  assign sel_we    = sel ? m1_we : m0_we;
  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign mem_we    = any_gnt ? sel_we : 4'b0000;
  assign mem_rd    = any_gnt && (sel_we == 4'b0000);
  assign mem_addr  = sel ? m1_addr : m0_addr;
  assign mem_wdata = sel ? m1_wdata : m0_wdata;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;
  assign m0_rvalid = rsp_valid_q && !rsp_owner_q;
  assign m1_rvalid = rsp_valid_q && rsp_owner_q;

  assign cnt_inc = (lock_cnt_q == CW'(LOCK_MAX)) ? lock_cnt_q : lock_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    last_gnt_d  = last_gnt_q;
    force_d     = force_q;
    rsp_valid_d = mem_rd;
    rsp_owner_d = sel;
    if (any_gnt) begin
      last_gnt_d = sel;
      force_d    = 1'b0;
    end
    case (state_q)
      OPEN: begin
        if (any_gnt && lock[sel]) begin
          owner_d = sel;
          if (LOCK_MAX <= 1) begin
            lock_cnt_d = CW'(1);
            force_d    = 1'b1;
          end else begin
            state_d    = LOCKED;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCKED: begin
        // A final unlocked access by the owner still gets its grant this cycle.
        if (!req[owner_q] || !lock[owner_q]) begin
          state_d    = OPEN;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = cnt_inc;
          if (cnt_inc == CW'(LOCK_MAX)) begin
            state_d = OPEN;
            force_d = 1'b1;
          end
        end
      end
      default: state_d = OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OPEN;
      owner_q     <= 1'b0;
      lock_cnt_q  <= '0;
      last_gnt_q  <= 1'b1;
      force_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      last_gnt_q  <= last_gnt_d;
      force_q     <= force_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8: maximum consecutive grants to one locked master.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports mN_req (N=0,1), input, 1 bit each: master N requests a data-memory access this cycle.
REQ-005 SHALL have ports mN_we, input, 4 bits each: byte write enables; nonzero means write, zero means read.
REQ-006 SHALL have ports mN_addr and mN_wdata, input, 32 bits each: byte address and write data.
REQ-007 SHALL have ports mN_lock, input, 1 bit each: hold the grant across consecutive requests (atomic read-modify-write).
REQ-008 SHALL have ports mN_gnt, output, 1 bit each: access accepted this cycle (combinational).
REQ-009 SHALL have ports mN_rvalid, output, 1 bit each: read data valid for master N (registered).
REQ-010 SHALL have ports mN_rdata, output, 32 bits each: read data, equal to mem_rdata.
REQ-011 SHALL have ports mem_rd (1 bit), mem_we (4 bits), mem_addr (32 bits) and mem_wdata (32 bits), all outputs: command to the data memory.
REQ-012 SHALL have port mem_rdata, input, 32 bits: data-memory read data, valid one cycle after mem_rd.

Function
REQ-013 SHALL grant at most one master per cycle; mN_gnt = 0 whenever mN_req = 0.
REQ-014 SHALL drive mem_* from the granted master in the same cycle: mem_rd = (we == 0), mem_we = we, with addr and wdata passed through.
REQ-015 SHALL hold mem_rd = 0 and mem_we = 0 in any cycle with no grant, so no spurious access occurs.
REQ-016 SHALL arbitrate round-robin: if both masters request, grant the master not granted most recently (last_gnt pointer).
REQ-017 SHALL update last_gnt only on cycles with a grant.
REQ-018 SHALL accept a new command every cycle; back-to-back reads are fully pipelined.
REQ-019 SHALL assert mN_rvalid exactly one cycle after granting a read to master N, for one cycle, using a registered owner tag.
REQ-020 SHALL never assert rvalid for writes, and never assert rvalid to both masters.
REQ-021 SHALL implement the lock FSM with two states, OPEN and LOCKED.
REQ-022 SHALL go from OPEN to LOCKED when the granted master has lock = 1; the owner is recorded and lock_cnt = 1.
REQ-023 SHALL, in LOCKED, grant only the owner, overriding round-robin.
REQ-024 SHALL increment lock_cnt on each owner grant while in LOCKED.
REQ-025 SHALL leave LOCKED for OPEN when any of the following holds:
- the owner drops lock;
- the owner drops req;
- lock_cnt reaches LOCK_MAX.
REQ-026 SHALL, on a LOCK_MAX exit, force the next arbitration to the other master if it is requesting (starvation guard).
REQ-027 SHALL, in LOCKED, ignore a lock request from the non-owner; that master waits without a grant.
REQ-028 SHALL use a lock_cnt register of $clog2(LOCK_MAX+1) bits that saturates and does not wrap.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously clear mN_rvalid = 0, FSM = OPEN, lock_cnt = 0, owner tag = 0, and set last_gnt = 1 so that m0 wins first.
REQ-030 SHALL drop a pending read response if reset asserts mid-read; no rvalid follows reset release.
REQ-031 SHALL produce mem_rd = 0 and mem_we = 0 combinationally during reset, because all gnt outputs are forced to 0.

Structure
REQ-032 SHALL take LOCK_MAX default and the FSM state enum (OPEN, LOCKED) from shared package dmem_arb_pkg.
REQ-033 SHALL place two-way round-robin selection in sub-module rr_pick2, with inputs req[1:0], last and force, and output gnt[1:0].
REQ-034 SHALL connect directly to the data memory, adding no data buffering (zero added latency on the command path).

Verification
REQ-035 SHALL cover: m0 read 0x10 alone -> m0_gnt in cycle 0, mem_rd = 1, mem_addr = 0x10; m0_rvalid in cycle 1 with m0_rdata = mem_rdata.
REQ-036 SHALL cover: both masters reading continuously for 6 cycles after reset -> grants m0, m1, m0, m1, m0, m1; rvalid alternates one cycle later.
REQ-037 SHALL cover: m1 write with we = 4'b0011 while m0 is idle -> mem_we = 0011 for one cycle; no rvalid on either master.
REQ-038 SHALL cover: m0 holds lock with req for 10 cycles while m1 also requests -> m0 granted 8 cycles, m1 granted in cycle 8, m1_gnt = 0 in cycles 0-7.
REQ-039 SHALL cover: rst_n asserted in the cycle after an m1 read grant -> m1_rvalid stays 0; after release, m0 is granted first on contention.
REQ-040 SHALL cover: no requests for 5 cycles -> mem_rd = 0, mem_we = 0, both gnt = 0, FSM stays OPEN.
